jtcontra_gfx_romarb: RTL and testbench
======================================

// Module: jtcontra_gfx_romarb
// PURPOSE
//  Shares one SDRAM read slot between the two graphics chips' ROM fetch ports
//   (gfx1/gfx2 tile+object ROM).
//  Round-robin arbitration with a one-word tag cache per requester.
//  Sits between the video block's gfx*_addr/romcs/data/ok ports and the SDRAM controller.
// PARAMETERS
//  AW        18          requester address width (16-bit words)
//  SDW       22          SDRAM word address width
//  GFX1_OFFSET 22'h0     SDRAM base added to gfx1 addresses
//  GFX2_OFFSET 22'h40000 SDRAM base added to gfx2 addresses
// PORTS
//  clk        in   1    system clock (48 MHz); single clock domain
//  rst        in   1    reset, synchronous, active-high
//  gfx1_cs    in   1    gfx1 ROM request enable
//  gfx1_addr  in   AW   gfx1 word address
//  gfx1_data  out  16   gfx1 read data
//  gfx1_ok    out  1    gfx1_data valid for current gfx1_addr
//  gfx2_cs    in   1    gfx2 ROM request enable
//  gfx2_addr  in   AW   gfx2 word address
//  gfx2_data  out  16   gfx2 read data
//  gfx2_ok    out  1    gfx2_data valid for current gfx2_addr
//  sdram_req  out  1    read request, held until sdram_ack
//  sdram_addr out  SDW  request address, stable while sdram_req or fetch pending
//  sdram_ack  in   1    1-cycle pulse: request accepted
//  sdram_rdy  in   1    1-cycle pulse: sdram_data valid
//  sdram_data in   16   SDRAM read word
// BEHAVIOUR
//  Per requester i: registers tag_i[AW], data_i[16], valid_i.
//   hit_i = valid_i & (gfxi_addr == tag_i).
//   gfxi_ok = gfxi_cs & hit_i (combinational: zero-latency hit, drops the same cycle addr changes).
//   gfxi_data = data_i (registered).
//  pend_i = gfxi_cs & ~hit_i.
//  FSM: IDLE -> REQ -> WAIT -> IDLE.
//   IDLE: if only one pend_i, serve it.
//    If both, serve the one != last (round-robin pointer, reset value: last=gfx2, so gfx1 wins first tie).
//    Latch sel, latched addr la = gfxi_addr; go REQ.
//   REQ: sdram_req=1, sdram_addr = OFFSET_sel + la (SDW-bit sum, overflow wraps).
//    On sdram_ack: go WAIT, deassert sdram_req next cycle.
//   WAIT: on sdram_rdy: data_sel<=sdram_data, tag_sel<=la, valid_sel<=1, last<=sel; go IDLE.
//  Minimum turnaround: request issued 1 cycle after pend rises; ok rises 1 cycle after sdram_rdy.
//  Boundary conditions:
//   - Requester addr changes or cs drops mid-fetch: fetch completes, cache fills with la; ok stays 0 unless addr==la again.
//     New miss is served next IDLE.
//   - sdram_ack and sdram_rdy in the same cycle while in REQ: treat as ack then rdy (fill, go IDLE).
//   - sdram_rdy/ack outside REQ/WAIT: ignored.
//   - Both requesters miss on the same address value: served separately (distinct offsets).
//  Reset: state=IDLE, sdram_req=0, sdram_addr=0, valid_i=0, tag_i=0, data_i=0, last=gfx2; all ok=0.
//   Reset mid-fetch abandons it; a late sdram_rdy is ignored.
// TESTING
//  1. gfx1_cs=1, addr=0x00010; SDRAM acks 2 cycles later, rdy 4 cycles later with 0xBEEF
//     -> sdram_addr=0x000010; gfx1_ok=1, gfx1_data=0xBEEF one cycle after rdy.
//  2. Both miss in same cycle from reset (gfx1 0x100, gfx2 0x200)
//     -> gfx1 served first at 0x000100, then gfx2 at 0x040200; a second tie serves gfx2 first.
//  3. After hit on 0x10, change gfx1_addr to 0x11
//     -> gfx1_ok=0 same cycle; new fetch issued; return to 0x10 mid-fetch gives ok=0 until refill.
//  4. Change gfx2_addr during WAIT
//     -> fill uses latched addr; gfx2_ok stays 0; a second request goes out with the new addr.
//  5. Assert rst while in WAIT, then pulse sdram_rdy
//     -> sdram_req=0, both ok=0, cache unchanged (invalid), FSM in IDLE.
//  6. ack and rdy in the same cycle -> single fill; FSM back in IDLE next cycle; no duplicate request.

Source files
------------

// File: rtl/jtcontra_gfx_romarb.sv
// -----------------------------------------------------------------------------
// jtcontra_gfx_romarb
//   Shares one SDRAM read slot between the two graphics chips' ROM fetch ports.
//   Each requester has a one-word cache: its tag, its data and a valid bit. A hit
//   is reported in the same cycle as the address. A miss is fetched from SDRAM.
//   When both requesters miss in the same cycle, a round-robin pointer picks one.
//
//   Handshake: sdram_req rises with a stable sdram_addr. It holds until the cycle
//   in which sdram_ack is sampled high. Later, a single sdram_rdy pulse carries
//   the word. sdram_addr keeps its value until the next request is launched.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   gfx1_cs/addr/data/ok      gfx1 ROM port (ok = data valid for current addr)
//   gfx2_cs/addr/data/ok      gfx2 ROM port
//   sdram_req/addr            read request towards the SDRAM controller
//   sdram_ack/rdy/data        request accepted / read data valid / read word
//   o_dbg_state               current FSM state (IDLE=0, REQ=1, WAIT=2)
// -----------------------------------------------------------------------------
module jtcontra_gfx_romarb #(
   parameter int             AW          = 18,
   parameter int             SDW         = 22,
   parameter logic [SDW-1:0] GFX1_OFFSET = 22'h0,
   parameter logic [SDW-1:0] GFX2_OFFSET = 22'h40000
)(
   input  logic           clk,
   input  logic           rst,
   input  logic           gfx1_cs,
   input  logic [AW-1:0]  gfx1_addr,
   output logic [15:0]    gfx1_data,
   output logic           gfx1_ok,
   input  logic           gfx2_cs,
   input  logic [AW-1:0]  gfx2_addr,
   output logic [15:0]    gfx2_data,
   output logic           gfx2_ok,
   output logic           sdram_req,
   output logic [SDW-1:0] sdram_addr,
   input  logic           sdram_ack,
   input  logic           sdram_rdy,
   input  logic [15:0]    sdram_data,
   output logic [1:0]     o_dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic [1:0]     r_state;
   logic           r_req;
   logic [SDW-1:0] r_addr;
   logic           r_sel;     // 0 = gfx1, 1 = gfx2
   logic           r_last;    // requester served most recently
   logic [AW-1:0]  r_la;      // address latched at launch
   logic [AW-1:0]  r_tag1, r_tag2;
   logic [15:0]    r_data1, r_data2;
   logic           r_valid1, r_valid2;

   logic           w_hit1, w_hit2;
   logic           w_pend1, w_pend2;
   logic           w_sel_nx;
   logic [AW-1:0]  w_la_nx;
   logic [SDW-1:0] w_off_nx;
   logic           w_fill;

   assign w_hit1  = r_valid1 & (gfx1_addr == r_tag1);
   assign w_hit2  = r_valid2 & (gfx2_addr == r_tag2);
   assign w_pend1 = gfx1_cs & ~w_hit1;
   assign w_pend2 = gfx2_cs & ~w_hit2;

   // On a tie, serve the requester that was not served last. Otherwise serve
   // whichever requester is pending.
   assign w_sel_nx = (w_pend1 & w_pend2) ? ~r_last : w_pend2;
   assign w_la_nx  = w_sel_nx ? gfx2_addr   : gfx1_addr;
   assign w_off_nx = w_sel_nx ? GFX2_OFFSET : GFX1_OFFSET;

   // If ack and rdy arrive together in REQ, the request counts as accepted and
   // answered in that same cycle.
   assign w_fill = ((r_state == ST_REQ) & sdram_ack & sdram_rdy) |
                   ((r_state == ST_WAIT) & sdram_rdy);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_sel    <= 1'b0;
         r_last   <= 1'b1;
         r_la     <= '0;
         r_tag1   <= '0;
         r_tag2   <= '0;
         r_data1  <= '0;
         r_data2  <= '0;
         r_valid1 <= 1'b0;
         r_valid2 <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pend1 | w_pend2) begin
                  r_sel   <= w_sel_nx;
                  r_la    <= w_la_nx;
                  r_addr  <= w_off_nx + SDW'(w_la_nx);
                  r_req   <= 1'b1;
                  r_state <= ST_REQ;
                  // The one-word entry is about to be replaced, so its old word
                  // must not keep reporting hits while the new one is in flight.
                  if (w_sel_nx) r_valid2 <= 1'b0;
                  else          r_valid1 <= 1'b0;
               end
            end
            ST_REQ: begin
               if (sdram_ack) begin
                  r_req   <= 1'b0;
                  r_state <= sdram_rdy ? ST_IDLE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (sdram_rdy) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase

         // Fill with the latched address, even if the requester has moved on.
         if (w_fill) begin
            r_last <= r_sel;
            if (r_sel) begin
               r_data2  <= sdram_data;
               r_tag2   <= r_la;
               r_valid2 <= 1'b1;
            end else begin
               r_data1  <= sdram_data;
               r_tag1   <= r_la;
               r_valid1 <= 1'b1;
            end
         end
      end
   end

   assign gfx1_ok     = gfx1_cs & w_hit1;
   assign gfx2_ok     = gfx2_cs & w_hit2;
   assign gfx1_data   = r_data1;
   assign gfx2_data   = r_data2;
   assign sdram_req   = r_req;
   assign sdram_addr  = r_addr;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// -----------------------------------------------------------------------------
// tb_jtcontra_gfx_romarb
//   Drives the two ROM ports and plays the SDRAM controller from tasks. Each
//   expected SDRAM address is queued when the miss is created. It is popped and
//   compared when the DUT raises sdram_req.
// -----------------------------------------------------------------------------
module tb_jtcontra_gfx_romarb;

   localparam int AW  = 18;
   localparam int SDW = 22;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic           clk = 1'b0;
   logic           rst;
   logic           gfx1_cs, gfx2_cs;
   logic [AW-1:0]  gfx1_addr, gfx2_addr;
   logic [15:0]    gfx1_data, gfx2_data;
   logic           gfx1_ok, gfx2_ok;
   logic           sdram_req;
   logic [SDW-1:0] sdram_addr;
   logic           sdram_ack, sdram_rdy;
   logic [15:0]    sdram_data;
   logic [1:0]     o_dbg_state;

   int n_cmp = 0;
   int n_err = 0;
   logic [SDW-1:0] exp_q[$];

   jtcontra_gfx_romarb dut (
      .clk         (clk),
      .rst         (rst),
      .gfx1_cs     (gfx1_cs),
      .gfx1_addr   (gfx1_addr),
      .gfx1_data   (gfx1_data),
      .gfx1_ok     (gfx1_ok),
      .gfx2_cs     (gfx2_cs),
      .gfx2_addr   (gfx2_addr),
      .gfx2_data   (gfx2_data),
      .gfx2_ok     (gfx2_ok),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .sdram_rdy   (sdram_rdy),
      .sdram_data  (sdram_data),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n;
      logic [SDW-1:0] e;
      n = 0;
      while (sdram_req !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
      chk("req_seen", 32'(sdram_req), 1);
      if (exp_q.size() == 0) begin
         chk("sb_depth", 32'(exp_q.size()), 1);
      end else begin
         e = exp_q.pop_front();
         chk("sdram_addr", 32'(sdram_addr), 32'(e));
      end
   endtask

   task automatic do_ack(input int dly);
      for (int i = 1; i < dly; i++) tick();
      chk("req_held", 32'(sdram_req), 1);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("req_drop", 32'(sdram_req), 0);
   endtask

   task automatic do_rdy(input int dly, input logic [15:0] d);
      for (int i = 1; i < dly; i++) tick();
      sdram_rdy  = 1'b1;
      sdram_data = d;
      tick();
      sdram_rdy  = 1'b0;
      sdram_data = 16'($urandom_range(0, 65535));
   endtask

   task automatic do_ack_rdy(input logic [15:0] d);
      sdram_ack  = 1'b1;
      sdram_rdy  = 1'b1;
      sdram_data = d;
      tick();
      sdram_ack  = 1'b0;
      sdram_rdy  = 1'b0;
      sdram_data = 16'($urandom_range(0, 65535));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst        = 1'b1;
      gfx1_cs    = 1'b1;
      gfx1_addr  = 18'h10;
      gfx2_cs    = 1'b0;
      gfx2_addr  = '0;
      sdram_ack  = 1'b0;
      sdram_rdy  = 1'b0;
      sdram_data = '0;
      tick();
      tick();

      // reset state, with a gfx1 miss already pending
      chk("rst_req",   32'(sdram_req), 0);
      chk("rst_addr",  32'(sdram_addr), 0);
      chk("rst_ok1",   32'(gfx1_ok), 0);
      chk("rst_ok2",   32'(gfx2_ok), 0);
      chk("rst_data1", 32'(gfx1_data), 0);
      chk("rst_data2", 32'(gfx2_data), 0);
      chk("rst_state", 32'(o_dbg_state), 32'(S_IDLE));

      // 1: basic miss, ack after 2 cycles, rdy 2 cycles after that
      rst = 1'b0;
      exp_q.push_back(22'h000010);
      tick();
      chk("t1_req_latency", 32'(sdram_req), 1);
      wait_req();
      do_ack(2);
      do_rdy(2, 16'hBEEF);
      chk("t1_ok1",   32'(gfx1_ok), 1);
      chk("t1_data1", 32'(gfx1_data), 32'h0000BEEF);
      chk("t1_state", 32'(o_dbg_state), 32'(S_IDLE));

      // 3: move off the cached word, then return to it mid-fetch
      gfx1_addr = 18'h11;
      #1;
      chk("t3_ok_drop", 32'(gfx1_ok), 0);
      exp_q.push_back(22'h000011);
      wait_req();
      do_ack(1);
      gfx1_addr = 18'h10;
      #1;
      chk("t3_back_midfetch", 32'(gfx1_ok), 0);
      do_rdy(3, 16'h1111);
      chk("t3_after_fill", 32'(gfx1_ok), 0);
      exp_q.push_back(22'h000010);
      wait_req();
      do_ack(1);
      do_rdy(1, 16'hBEEF);
      chk("t3_refill_ok", 32'(gfx1_ok), 1);
      chk("t3_refill_data", 32'(gfx1_data), 32'h0000BEEF);

      // 2: simultaneous misses from reset, then a second tie
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      gfx1_addr = 18'h100;
      gfx2_cs   = 1'b1;
      gfx2_addr = 18'h200;
      exp_q.push_back(22'h000100);
      exp_q.push_back(22'h040200);
      wait_req();
      do_ack($urandom_range(1, 3));
      do_rdy($urandom_range(1, 3), 16'h2101);
      chk("t2_ok1_first", 32'(gfx1_ok), 1);
      chk("t2_ok2_wait",  32'(gfx2_ok), 0);
      gfx1_addr = 18'h101;
      exp_q.push_back(22'h000101);
      wait_req();
      do_ack($urandom_range(1, 3));
      do_rdy($urandom_range(1, 3), 16'h2202);
      chk("t2_ok2",   32'(gfx2_ok), 1);
      chk("t2_data2", 32'(gfx2_data), 32'h00002202);
      chk("t2_ok1_miss", 32'(gfx1_ok), 0);
      wait_req();
      do_ack(1);
      do_rdy(1, 16'h2303);
      chk("t2_ok1_second", 32'(gfx1_ok), 1);
      chk("t2_data1",      32'(gfx1_data), 32'h00002303);

      // 4: gfx2 moves during WAIT
      gfx1_cs   = 1'b0;
      gfx2_addr = 18'h300;
      exp_q.push_back(22'h040300);
      wait_req();
      do_ack(2);
      gfx2_addr = 18'h301;
      exp_q.push_back(22'h040301);
      do_rdy(2, 16'h4300);
      chk("t4_stale_ok", 32'(gfx2_ok), 0);
      wait_req();
      do_ack(1);
      do_rdy(1, 16'h4301);
      chk("t4_new_ok",   32'(gfx2_ok), 1);
      chk("t4_new_data", 32'(gfx2_data), 32'h00004301);

      // 5: reset during WAIT, then a late rdy
      gfx2_cs   = 1'b0;
      gfx1_cs   = 1'b1;
      gfx1_addr = 18'h500;
      exp_q.push_back(22'h000500);
      wait_req();
      do_ack(1);
      chk("t5_in_wait", 32'(o_dbg_state), 32'(S_WAIT));
      rst     = 1'b1;
      gfx1_cs = 1'b0;
      tick();
      rst        = 1'b0;
      sdram_rdy  = 1'b1;
      sdram_data = 16'hDEAD;
      tick();
      sdram_rdy = 1'b0;
      chk("t5_req",   32'(sdram_req), 0);
      chk("t5_state", 32'(o_dbg_state), 32'(S_IDLE));
      chk("t5_data1", 32'(gfx1_data), 0);
      chk("t5_data2", 32'(gfx2_data), 0);
      gfx1_cs = 1'b1;
      gfx2_cs = 1'b1;
      #1;
      chk("t5_ok1", 32'(gfx1_ok), 0);
      chk("t5_ok2", 32'(gfx2_ok), 0);
      exp_q.push_back(22'h000500);
      exp_q.push_back(22'h040301);
      wait_req();
      do_ack(1);
      do_rdy(2, 16'h5500);
      chk("t5_ok1_fill", 32'(gfx1_ok), 1);
      chk("t5_data1_fill", 32'(gfx1_data), 32'h00005500);

      // 6: ack and rdy in the same cycle
      wait_req();
      do_ack_rdy(16'h6301);
      chk("t6_state", 32'(o_dbg_state), 32'(S_IDLE));
      chk("t6_req",   32'(sdram_req), 0);
      chk("t6_ok2",   32'(gfx2_ok), 1);
      chk("t6_data2", 32'(gfx2_data), 32'h00006301);
      tick();
      chk("t6_no_dup_req",   32'(sdram_req), 0);
      chk("t6_no_dup_state", 32'(o_dbg_state), 32'(S_IDLE));

      // stray rdy and ack while idle are ignored
      sdram_rdy  = 1'b1;
      sdram_data = 16'h7777;
      tick();
      sdram_rdy = 1'b0;
      chk("stray_rdy_d2", 32'(gfx2_data), 32'h00006301);
      chk("stray_rdy_d1", 32'(gfx1_data), 32'h00005500);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("stray_ack_state", 32'(o_dbg_state), 32'(S_IDLE));
      chk("stray_ack_req",   32'(sdram_req), 0);

      chk("sb_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
